// File: rtl/synch_fifo_pkg.sv
// Shared defaults and helpers for the programmable-threshold synchronous FIFO.
package synch_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Fill level needs one extra bit so that count==DEPTH is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/synch_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module synch_fifo_mem
    import synch_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-before-write: a same-address read sees the old word, which is
    // exactly what a full FIFO doing a simultaneous push/pop needs.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[waddr] <= wdata;
        if (rd_en) rdata <= mem[raddr];
    end

endmodule

// File: rtl/synch_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty levels and error flags.
// Define SYNCH_FIFO_STICKY_ERR_EN for sticky overflow/underflow cleared by err_clr_i.
module synch_fifo_prog
    import synch_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [WIDTH-1:0]              wdata_i,
    input  logic                          rd_en_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          rvalid_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                          overflow_o,
    output logic                          underflow_o,
    input  logic                          err_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             wr_acc;
    logic             rd_acc;
    logic             rd_seen;
    logic [WIDTH-1:0] mem_rdata;

    assign count_o        = count;
    assign full_o         = (count == FULL_C);
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);

    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);

    synch_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i (clk_i),
        .wr_en (wr_acc),
        .waddr (wptr),
        .wdata (wdata_i),
        .rd_en (rd_acc),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    // The RAM read register has no reset, so rdata_o reads as zero until the
    // first pop after reset; afterwards it holds the last popped word.
    assign rdata_o = rd_seen ? mem_rdata : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rvalid_o <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            if (rd_acc) rptr <= rptr + AW'(1);
            if (wr_acc && !rd_acc)      count <= count + CW'(1);
            else if (rd_acc && !wr_acc) count <= count - CW'(1);
            rvalid_o <= rd_acc;
            if (rd_acc) rd_seen <= 1'b1;
        end
    end

    logic ovf_evt;
    logic udf_evt;
    assign ovf_evt = wr_en_i && !wr_acc;
    assign udf_evt = rd_en_i && !rd_acc;

`ifdef SYNCH_FIFO_STICKY_ERR_EN
    // A new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_evt || (overflow_o && !err_clr_i);
            underflow_o <= udf_evt || (underflow_o && !err_clr_i);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_evt;
            underflow_o <= udf_evt;
        end
    end
`endif

endmodule

// File: tb/tb_synch_fifo_prog.sv
// Directed bench for synch_fifo_prog: vector table plus hand sequences.
module tb_synch_fifo_prog;

`ifdef SYNCH_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_en_i = 1'b0;
    logic [7:0] wdata_i = '0;
    logic       rd_en_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] rdata_o;
    logic       rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic [4:0] count_o;
    logic       overflow_o, underflow_o;

    synch_fifo_prog dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wdata_i        (wdata_i),
        .rd_en_i        (rd_en_i),
        .rdata_o        (rdata_o),
        .rvalid_o       (rvalid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .err_clr_i      (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Behavioural reference: a queue plus expected output registers.
    int       q[$];
    bit [7:0] m_rdata;
    bit       m_rvalid, m_ovf, m_udf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},  int'(count_o), q.size());
        chk({tag, ".rvalid"}, int'(rvalid_o), int'(m_rvalid));
        chk({tag, ".rdata"},  int'(rdata_o), int'(m_rdata));
        chk({tag, ".full"},   int'(full_o), int'(q.size() == DEPTH));
        chk({tag, ".empty"},  int'(empty_o), int'(q.size() == 0));
        chk({tag, ".afull"},  int'(almost_full_o), int'(q.size() >= DEPTH - 2));
        chk({tag, ".aempty"}, int'(almost_empty_o), int'(q.size() <= 2));
        chk({tag, ".ovf"},    int'(overflow_o), int'(m_ovf));
        chk({tag, ".udf"},    int'(underflow_o), int'(m_udf));
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit wr, input bit [7:0] d, input bit rd, input bit clr);
        bit racc, wacc;
        wr_en_i = wr; wdata_i = d; rd_en_i = rd; err_clr_i = clr;
        racc = rd && (q.size() > 0);
        wacc = wr && ((q.size() < DEPTH) || racc);
        m_rvalid = racc;
        if (racc) m_rdata = 8'(q.pop_front());
        if (wacc) q.push_back(int'(d));
        m_ovf = (wr && !wacc) || (STICKY && m_ovf && !clr);
        m_udf = (rd && !racc) || (STICKY && m_udf && !clr);
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0; rd_en_i = 1'b0; err_clr_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".count"},  int'(count_o), 0);
        chk({tag, ".rdata"},  int'(rdata_o), 0);
        chk({tag, ".rvalid"}, int'(rvalid_o), 0);
        chk({tag, ".empty"},  int'(empty_o), 1);
        chk({tag, ".aempty"}, int'(almost_empty_o), 1);
        chk({tag, ".full"},   int'(full_o), 0);
        chk({tag, ".afull"},  int'(almost_full_o), 0);
        chk({tag, ".ovf"},    int'(overflow_o), 0);
        chk({tag, ".udf"},    int'(underflow_o), 0);
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic pulse_reset(input string tag);
        rst_i = 1'b1;
        #1;
        check_reset_vals(tag);
        q.delete();
        m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        wr_en_i = 1'b0; rd_en_i = 1'b0; err_clr_i = 1'b0;
    endtask

    typedef struct {
        bit       wr;
        bit [7:0] d;
        bit       rd;
        bit       clr;
        bit       e_rvalid;
        bit [7:0] e_rdata;
        int       e_count;
        bit       e_empty;
        bit       e_ae;
        bit       e_ovf;
        bit       e_udf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //          wr  d      rd clr rv  rdata  cnt emp ae  ovf udf
        vecs[0]  = '{1, 8'h11, 0, 0,  0, 8'h00, 1,  0,  1,  0,  0};
        vecs[1]  = '{1, 8'h22, 0, 0,  0, 8'h00, 2,  0,  1,  0,  0};
        vecs[2]  = '{1, 8'h33, 0, 0,  0, 8'h00, 3,  0,  0,  0,  0};
        vecs[3]  = '{0, 8'h00, 1, 0,  1, 8'h11, 2,  0,  1,  0,  0};
        vecs[4]  = '{1, 8'h44, 1, 0,  1, 8'h22, 2,  0,  1,  0,  0};
        vecs[5]  = '{0, 8'h00, 0, 0,  0, 8'h22, 2,  0,  1,  0,  0};
        vecs[6]  = '{0, 8'h00, 1, 0,  1, 8'h33, 1,  0,  1,  0,  0};
        vecs[7]  = '{0, 8'h00, 1, 0,  1, 8'h44, 0,  1,  1,  0,  0};
        vecs[8]  = '{0, 8'h00, 1, 0,  0, 8'h44, 0,  1,  1,  0,  1};
        vecs[9]  = '{1, 8'h55, 1, 0,  0, 8'h44, 1,  0,  1,  0,  1};
        vecs[10] = '{0, 8'h00, 0, 1,  0, 8'h44, 1,  0,  1,  0,  0};
        vecs[11] = '{0, 8'h00, 1, 0,  1, 8'h55, 0,  1,  1,  0,  0};

        #2;
        check_reset_vals("reset");
        pulse_reset("reset2");

        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
            chk({t, ".rvalid"}, int'(rvalid_o), int'(vecs[i].e_rvalid));
            chk({t, ".rdata"},  int'(rdata_o), int'(vecs[i].e_rdata));
            chk({t, ".count"},  int'(count_o), vecs[i].e_count);
            chk({t, ".empty"},  int'(empty_o), int'(vecs[i].e_empty));
            chk({t, ".aempty"}, int'(almost_empty_o), int'(vecs[i].e_ae));
            chk({t, ".ovf"},    int'(overflow_o), int'(vecs[i].e_ovf));
            chk({t, ".udf"},    int'(underflow_o), int'(vecs[i].e_udf));
        end

        // Fill to full, watching almost-full assert at 14.
        pulse_reset("rst_fill");
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 0, 0);
            check_model($sformatf("fill%0d", i));
            if (i == 13) chk("afull_at13", int'(almost_full_o), 0);
            if (i == 14) chk("afull_at14", int'(almost_full_o), 1);
        end
        chk("full_at16", int'(full_o), 1);
        step(1, 8'h99, 0, 0);
        check_model("write17");
        chk("ovf_write17", int'(overflow_o), 1);
        chk("count_write17", int'(count_o), 16);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, 0);
            check_model($sformatf("ovf_idle%0d", i));
        end
        chk("ovf_after_idle", int'(overflow_o), int'(STICKY));
        step(0, 8'h00, 0, 1);
        check_model("ovf_clr");
        chk("ovf_cleared", int'(overflow_o), 0);

        // Full push/pop, then drain: 0x02..0x10 followed by 0xAA.
        step(1, 8'hAA, 1, 0);
        check_model("full_wr_rd");
        chk("full_wr_rd.rdata", int'(rdata_o), 8'h01);
        chk("full_wr_rd.count", int'(count_o), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0);
            check_model($sformatf("drain%0d", i));
        end
        chk("drain_last_aa", int'(rdata_o), 8'hAA);
        chk("drain_empty", int'(empty_o), 1);
        step(0, 8'h00, 1, 0);
        check_model("drain_udf");
        chk("drain_udf.flag", int'(underflow_o), 1);
        chk("drain_udf.rvalid", int'(rvalid_o), 0);
        step(0, 8'h00, 0, 1);

        // Interleaved traffic wrapping both pointers more than twice.
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(8'h40 + i), (i >= 3), 0);
            check_model($sformatf("wrap%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 0);
            check_model($sformatf("wrap_drain%0d", i));
        end
        chk("wrap_last", int'(rdata_o), 8'h40 + 39);

        // Reset mid-burst, then a fresh word must come back first.
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        wr_en_i = 1'b1; wdata_i = 8'h03; rd_en_i = 1'b1;
        pulse_reset("rst_mid");
        step(1, 8'h5A, 0, 0);
        check_model("post_rst_wr");
        step(0, 8'h00, 1, 0);
        check_model("post_rst_rd");
        chk("post_rst_data", int'(rdata_o), 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
